logic_dispatch: RTL and testbench

Request-side front end for the 64-bit registered logic unit (NOT/AND/OR/XOR, 1-cycle registered result).
- Accepts tagged operation requests over a valid/ready handshake and drives the unit's ctrl/op1/op2 inputs from registers.
- Tracks in-flight operations through the unit's one-cycle latency and captures dst into an in-order response FIFO.
- Returns results with their tags over a valid/ready handshake, using credit-based flow control so no result is ever dropped.

---
 rtl/logic_pkg.sv | 39 +++
 rtl/logic_rsp_fifo.sv | 77 +++++++
 rtl/logic_dispatch.sv | 127 ++++++++++++
 tb/tb_logic_dispatch.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// ---------------------------------------------------------------------------
// logic_pkg
// Shared definitions for the 64-bit registered logic unit and its dispatch
// front end.
//   LOGIC_W    : operand / result width
//   LOGIC_LAT  : clock edges from ctrl/op1/op2 to a registered dst
//   LOGIC_*    : 2-bit operation encodings on the unit's ctrl input
//   logic_eval : combinational reference for what the unit computes; the
//                unit registers this value once per clock
// ---------------------------------------------------------------------------
package logic_pkg;

  localparam int LOGIC_W   = 64;
  localparam int LOGIC_LAT = 1;

  localparam logic [1:0] LOGIC_NOT = 2'b00;
  localparam logic [1:0] LOGIC_AND = 2'b01;
  localparam logic [1:0] LOGIC_OR  = 2'b10;
  localparam logic [1:0] LOGIC_XOR = 2'b11;

  // Result of one logic unit operation. NOT ignores b.
  function automatic logic [LOGIC_W-1:0] logic_eval(
    input logic [1:0]         op,
    input logic [LOGIC_W-1:0] a,
    input logic [LOGIC_W-1:0] b
  );
    logic [LOGIC_W-1:0] r;
    r = '0;
    case (op)
      LOGIC_NOT: r = ~a;
      LOGIC_AND: r = a & b;
      LOGIC_OR:  r = a | b;
      LOGIC_XOR: r = a ^ b;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_rsp_fifo.sv
// ---------------------------------------------------------------------------
// logic_rsp_fifo
// In-order, first-word-fall-through response FIFO. The head entry is always
// visible on head_data, so a consumer can take it the same cycle it appears.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears storage too)
//   push       : write push_data at the tail
//   push_data  : entry to store (W bits)
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry
//   count      : number of stored entries, 0..DEPTH
//   empty      : count == 0
// ---------------------------------------------------------------------------
module logic_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop only happens when there is something to pop. A push into a full
  // FIFO is allowed only when the head leaves on the same edge, which frees
  // exactly the slot the write pointer is sitting on.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and count. Pointers are log2(DEPTH) bits and wrap on
  // their own because DEPTH is a power of two. Storage is cleared on reset
  // so the head reads as zero after reset rather than a stale result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  // The dispatch credit scheme should make this impossible; if it fires, a
  // result has been lost.
  push_on_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: rtl/logic_dispatch.sv
// ---------------------------------------------------------------------------
// logic_dispatch
// Request-side front end for the registered 64-bit logic unit. Takes tagged
// requests, drives the unit from registers, follows each op through the
// unit's latency and queues {dst, tag} in an in-order response FIFO. Credits
// (ops in flight + queued entries) gate req_ready so no result is dropped.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_op, req_a, req_b     : operation and operands
//   req_tag                  : opaque tag returned with the result
//   lu_ctrl, lu_op1, lu_op2  : registered drive into the logic unit
//   lu_dst                   : registered result from the logic unit
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data, rsp_tag        : head-of-queue result and its tag
//   busy                     : anything in flight or queued
//   ops_done                 : responses consumed, wraps at 2^32
// ---------------------------------------------------------------------------
module logic_dispatch
  import logic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [LOGIC_W-1:0] req_a,
  input  logic [LOGIC_W-1:0] req_b,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [1:0]         lu_ctrl,
  output logic [LOGIC_W-1:0] lu_op1,
  output logic [LOGIC_W-1:0] lu_op2,
  input  logic [LOGIC_W-1:0] lu_dst,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [LOGIC_W-1:0] rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy,
  output logic [31:0]        ops_done
);

  // One stage for the issue registers plus one per edge of unit latency.
  localparam int STAGES = 1 + LOGIC_LAT;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int OW     = CW + 1;
  localparam int EW     = LOGIC_W + TAG_W;

  logic [STAGES-1:0] vpipe;
  logic [TAG_W-1:0]  tagpipe [STAGES];
  logic              accept;
  logic              pop;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [OW-1:0]     occupancy;

  assign accept = req_valid && req_ready;
  assign pop    = rsp_valid && rsp_ready;

  // Credits: every op that has been accepted and not yet consumed holds a
  // slot. Only registered state feeds this, so req_ready never combinationally
  // follows req_valid or rsp_ready, and a pop frees its slot one cycle later.
  always_comb begin
    occupancy = OW'(fifo_count);
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(vpipe[i]);
  end

  assign req_ready = (occupancy < OW'(DEPTH));

  // Issue registers into the logic unit. They only move on an accept so the
  // unit's inputs stay quiet between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_ctrl <= '0;
      lu_op1  <= '0;
      lu_op2  <= '0;
    end else if (accept) begin
      lu_ctrl <= req_op;
      lu_op1  <= req_a;
      lu_op2  <= req_b;
    end
  end

  // Valid/tag shift that shadows the op through the issue register and the
  // unit's internal result register. When the last stage is valid, lu_dst
  // holds that op's result and it is written into the FIFO on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
      for (int i = 0; i < STAGES; i++) tagpipe[i] <= '0;
    end else begin
      vpipe <= {vpipe[STAGES-2:0], accept};
      if (accept) tagpipe[0] <= req_tag;
      for (int i = 1; i < STAGES; i++) tagpipe[i] <= tagpipe[i-1];
    end
  end

  logic_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vpipe[STAGES-1]),
    .push_data ({lu_dst, tagpipe[STAGES-1]}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_head[EW-1:TAG_W];
  assign rsp_tag   = fifo_head[TAG_W-1:0];
  assign busy      = (|vpipe) || (fifo_count != '0);

  // Consumed-response counter; the add is unconditional and simply wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ops_done <= '0;
    else     ops_done <= ops_done + 32'(pop);
  end

endmodule

// File: tb/tb_logic_dispatch.sv
// ---------------------------------------------------------------------------
// tb_logic_dispatch
// Bench for logic_dispatch with a registered logic unit attached. A monitor
// keeps an abstract model (queue of expected results with earliest-visible
// cycle, outstanding count, consumed count) and checks every cycle; directed
// vectors and sequences cover latency, back-to-back, backpressure, full FIFO,
// reset mid-operation and counter wrap; a random phase follows.
// ---------------------------------------------------------------------------
module tb_logic_dispatch;
  import logic_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_tag;
  logic [1:0]  lu_ctrl;
  logic [63:0] lu_op1;
  logic [63:0] lu_op2;
  logic [63:0] lu_dst;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [31:0] ops_done;

  logic_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .lu_ctrl   (lu_ctrl),
    .lu_op1    (lu_op1),
    .lu_op2    (lu_op2),
    .lu_dst    (lu_dst),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  // The attached logic unit: one registered result per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lu_dst <= '0;
    else     lu_dst <= logic_eval(lu_ctrl, lu_op1, lu_op2);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Result of an operation straight from the op definitions.
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    if (op == 2'd0)      return ~a;
    else if (op == 2'd1) return a & b;
    else if (op == 2'd2) return a | b;
    else                 return a ^ b;
  endfunction

  // Abstract model: results pending in order, each visible from cycle rdy.
  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    int          rdy;
  } exp_t;

  exp_t        expq[$];
  logic [3:0]  popped[$];
  int          cyc         = 0;
  int          outstanding = 0;
  int          n_accept    = 0;
  logic [31:0] exp_done    = '0;
  logic        exp_valid;

  task automatic model_clear();
    expq.delete();
    popped.delete();
    outstanding = 0;
    exp_done    = '0;
  endtask

  // Monitor at the falling edge: checks the outputs against the model, then
  // applies the handshakes that will take place at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      checkOutput("req_ready", 64'(req_ready), 64'(outstanding < DEPTH));
      checkOutput("busy", 64'(busy), 64'(outstanding != 0));
      checkOutput("ops_done", 64'(ops_done), 64'(exp_done));
      exp_valid = (expq.size() > 0) && (cyc >= expq[0].rdy);
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (rsp_valid && exp_valid) begin
        checkOutput("rsp_data", rsp_data, expq[0].data);
        checkOutput("rsp_tag", 64'(rsp_tag), 64'(expq[0].tag));
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() > 0) void'(expq.pop_front());
        popped.push_back(rsp_tag);
        outstanding--;
        exp_done = exp_done + 32'd1;
      end
      if (req_valid && req_ready) begin
        expq.push_back('{ref_result(req_op, req_a, req_b), req_tag, cyc + 3});
        outstanding++;
        n_accept++;
      end
    end
  end

  // Drives one request and returns one ns after the edge that accepted it.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] tag);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("req_accepted", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts falling edges until rsp_valid shows; stays at that falling edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] exp_data;
  } vec_t;

  localparam logic [63:0] PA = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] PB = 64'h0F0F0F0F0F0F0F0F;

  vec_t        vecs[6];
  int          lat;
  int          base;
  int          cyc0;
  logic [63:0] b2b_exp[3];

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{LOGIC_XOR, PA, PB, 4'd3, 64'hF0F00F0FF0F00F0F};
    vecs[1] = '{LOGIC_NOT, 64'h0123456789ABCDEF, 64'h0, 4'd7, 64'hFEDCBA9876543210};
    vecs[2] = '{LOGIC_AND, 64'h0, 64'hFFFFFFFFFFFFFFFF, 4'd15, 64'h0};
    vecs[3] = '{LOGIC_XOR, 64'hFFFFFFFFFFFFFFFF, 64'h0, 4'd0, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{LOGIC_OR, 64'h8000000000000000, 64'h1, 4'd9, 64'h8000000000000001};
    vecs[5] = '{LOGIC_AND, PA, PB, 4'd12, 64'h0F0F00000F0F0000};
    b2b_exp[0] = 64'h0000FFFF0000FFFF;
    b2b_exp[1] = 64'h0F0F00000F0F0000;
    b2b_exp[2] = 64'hFFFF0F0FFFFF0F0F;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    model_clear();
    #3;
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_ops_done", 64'(ops_done), 64'd0);
    checkOutput("rst_lu_op1", lu_op1, 64'd0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ops from the table, one at a time, with latency check
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rsp(lat);
      checkOutput("vec_latency", 64'(lat), 64'd3);
      checkOutput("vec_data", rsp_data, vecs[i].exp_data);
      checkOutput("vec_tag", 64'(rsp_tag), 64'(vecs[i].tag));
      @(posedge clk);
      #1;
    end
    wait_idle();
    checkOutput("ops_done_after_table", 64'(ops_done), 64'd6);
    checkOutput("busy_after_table", 64'(busy), 64'd0);

    // Back-to-back NOT/AND/OR
    cyc0 = cyc;
    applyStimulus(LOGIC_NOT, PA, PB, 4'd0);
    applyStimulus(LOGIC_AND, PA, PB, 4'd1);
    applyStimulus(LOGIC_OR, PA, PB, 4'd2);
    checkOutput("b2b_issue_cycles", 64'(cyc - cyc0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("b2b_data", rsp_data, b2b_exp[i]);
      checkOutput("b2b_tag", 64'(rsp_tag), 64'(i));
    end
    @(posedge clk);
    #1;
    wait_idle();

    // Backpressure: six requests offered, four fit
    rsp_ready = 1'b0;
    base = n_accept;
    popped.delete();
    for (int t = 0; t < 4; t++) applyStimulus(2'(t), PA, 64'(t) * PB, 4'(t));
    req_valid = 1'b1;
    req_op    = LOGIC_XOR;
    req_tag   = 4'd4;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
      checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_data", rsp_data, ref_result(2'd0, PA, 64'd0));
      checkOutput("stall_tag", 64'(rsp_tag), 64'd0);
    end
    checkOutput("accepted_under_stall", 64'(n_accept - base), 64'd4);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    applyStimulus(LOGIC_XOR, PA, PB, 4'd4);
    applyStimulus(LOGIC_OR, PB, PA, 4'd5);
    wait_idle();
    checkOutput("bp_popped_count", 64'(popped.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      checkOutput("bp_popped_order", 64'(popped[i]), 64'(i));

    // Full FIFO: pop and new request in the same cycle
    rsp_ready = 1'b0;
    popped.delete();
    for (int t = 8; t < 12; t++) applyStimulus(LOGIC_AND, 64'(t) * PA, PB, 4'(t));
    wait_cycles(3);
    req_valid = 1'b1;
    req_op    = LOGIC_NOT;
    req_a     = PB;
    req_tag   = 4'd12;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_pop_req_ready", 64'(req_ready), 64'd0);
    checkOutput("full_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("after_pop_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    checkOutput("full_popped_count", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      checkOutput("full_popped_order", 64'(popped[i]), 64'(i + 8));
    checkOutput("full_ops_done", 64'(ops_done), 64'(exp_done));

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_op    = 2'($urandom_range(0, 3));
      req_a     = {$urandom(), $urandom()};
      req_b     = {$urandom(), $urandom()};
      req_tag   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset with two queued and two in flight
    rsp_ready = 1'b0;
    applyStimulus(LOGIC_AND, PA, PB, 4'd0);
    applyStimulus(LOGIC_OR, PA, PB, 4'd1);
    wait_cycles(2);
    applyStimulus(LOGIC_XOR, PA, PB, 4'd2);
    applyStimulus(LOGIC_NOT, PA, PB, 4'd3);
    #2 rst = 1'b1;
    model_clear();
    #1;
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_ops_done", 64'(ops_done), 64'd0);
    checkOutput("midrst_rsp_data", rsp_data, 64'd0);
    checkOutput("midrst_rsp_tag", 64'(rsp_tag), 64'd0);
    checkOutput("midrst_lu_ctrl", 64'(lu_ctrl), 64'd0);
    checkOutput("midrst_lu_op1", lu_op1, 64'd0);
    checkOutput("midrst_lu_op2", lu_op2, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    rsp_ready = 1'b1;
    wait_cycles(6);
    checkOutput("midrst_no_stale", 64'(popped.size()), 64'd0);
    applyStimulus(LOGIC_XOR, PA, PB, 4'd6);
    wait_rsp(lat);
    checkOutput("post_rst_latency", 64'(lat), 64'd3);
    checkOutput("post_rst_data", rsp_data, 64'hF0F00F0FF0F00F0F);
    checkOutput("post_rst_tag", 64'(rsp_tag), 64'd6);
    @(posedge clk);
    #1;
    wait_idle();
    checkOutput("post_rst_ops_done", 64'(ops_done), 64'd1);

    // ops_done wrap
    rsp_ready = 1'b0;
    force dut.ops_done = 32'hFFFFFFFF;
    exp_done = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut.ops_done;
    checkOutput("ops_done_preload", 64'(ops_done), 64'hFFFFFFFF);
    rsp_ready = 1'b1;
    applyStimulus(LOGIC_AND, PA, PB, 4'd1);
    wait_rsp(lat);
    @(posedge clk);
    #1;
    checkOutput("ops_done_wrap", 64'(ops_done), 64'd0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
